time_set_ctrl: RTL and testbench

Time-setting controller for the digital clock. It turns the three raw push-buttons into a mode state machine (run / set hour / set minute / set second). It generates single-cycle up/down step strobes for the field being edited, with press-and-hold auto-repeat. It freezes the seconds tick chain while a field is edited, and supplies a blink enable for the edited display digits.

---
 rtl/time_set_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   Time-setting controller for the digital clock. It conditions the three raw
//   push-buttons, steps a mode FSM through RUN / SET_HOUR / SET_MIN / SET_SEC,
//   emits single-cycle up/down step strobes with press-and-hold auto-repeat,
//   freezes the seconds chain while editing and drives the edit blink.
//
// Ports
//   clk50      in   system clock, all flops on rising edge
//   reset      in   asynchronous active-high reset
//   btn_mode   in   raw mode button, active-low, asynchronous
//   btn_up     in   raw up button, active-low, asynchronous
//   btn_down   in   raw down button, active-low, asynchronous
//   mode       out  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
//   step_up    out  one-cycle increment strobe for the selected field
//   step_down  out  one-cycle decrement strobe for the selected field
//   run_en     out  1 = seconds tick may propagate, 0 = time frozen
//   blink      out  display enable for the edited field, 1 in RUN
// -----------------------------------------------------------------------------
module time_set_ctrl #(
  parameter int DEBOUNCE     = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int TIMEOUT      = 500000000,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic       step_up,
  output logic       step_down,
  output logic       run_en,
  output logic       blink
);

  localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BL_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam int B_MODE = 0;
  localparam int B_UP   = 1;
  localparam int B_DN   = 2;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } mode_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer + debounce, one lane per button.
  // Levels are active-low, so the released/idle value is 1.
  // ---------------------------------------------------------------------------
  logic [2:0]      sync1, sync2, db, db_d;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      press;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      db_d  <= '1;
      // NOTE: the debounce counters are a handful of control flops, not a
      // memory, so they are reset element by element like any other state.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns sync1 -> sync2 into a real two-stage chain.
      sync1 <= {btn_down, btn_up, btn_mode};
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press event: debounced 1 -> 0 transition, valid for exactly one cycle.
  assign press = db_d & ~db;

  logic up_held, dn_held;
  assign up_held = ~db[B_UP];
  assign dn_held = ~db[B_DN];

  // ---------------------------------------------------------------------------
  // Mode FSM, step/auto-repeat engine, timeout and blink.
  // ---------------------------------------------------------------------------
  mode_t            mode_q, mode_nxt;
  logic             rpt_act, rpt_dir, rpt_first;
  logic [RPT_W-1:0] rpt_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [BL_W-1:0]  bl_cnt;
  logic             in_set, timeout_hit, mode_chg;

  assign in_set      = (mode_q != RUN);
  // Any press event in the timeout cycle wins: it clears the counter instead.
  assign timeout_hit = in_set && (to_cnt == TO_W'(TIMEOUT - 1)) && (press == 3'b000);
  assign mode_chg    = press[B_MODE] || timeout_hit;

  always_comb begin
    // NOTE: assigning a default first keeps this purely combinational; a path
    // that left mode_nxt unassigned would infer a latch.
    mode_nxt = mode_q;
    if (press[B_MODE])    mode_nxt = mode_t'(mode_q + 2'd1);
    else if (timeout_hit) mode_nxt = RUN;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      mode_q    <= RUN;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      rpt_act   <= 1'b0;
      rpt_dir   <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
      to_cnt    <= '0;
      bl_cnt    <= '0;
      blink     <= 1'b1;
    end else begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
      mode_q    <= mode_nxt;

      // Timeout: held at 0 in RUN, cleared on entry and on any press.
      if (mode_nxt == RUN || mode_chg || press != 3'b000) to_cnt <= '0;
      else                                                to_cnt <= to_cnt + 1'b1;

      // Blink divider restarts at every mode change with the field visible.
      if (mode_nxt == RUN || mode_chg) begin
        bl_cnt <= '0;
        blink  <= 1'b1;
      end else if (bl_cnt == BL_W'(BLINK_DIV - 1)) begin
        bl_cnt <= '0;
        blink  <= ~blink;
      end else begin
        bl_cnt <= bl_cnt + 1'b1;
      end

      // Steps. Repeat only ever starts from a fresh press event, so cancelling
      // it (mode change, both held, RUN) locks the held button out until it is
      // released and pressed again.
      if (mode_chg || !in_set || (up_held && dn_held)) begin
        rpt_act <= 1'b0;
        rpt_cnt <= '0;
      end else if (press[B_UP]) begin
        step_up   <= 1'b1;
        rpt_act   <= 1'b1;
        rpt_dir   <= 1'b1;
        rpt_first <= 1'b1;
        rpt_cnt   <= '0;
      end else if (press[B_DN]) begin
        step_down <= 1'b1;
        rpt_act   <= 1'b1;
        rpt_dir   <= 1'b0;
        rpt_first <= 1'b1;
        rpt_cnt   <= '0;
      end else if (rpt_act) begin
        if (rpt_dir ? !up_held : !dn_held) begin
          rpt_act <= 1'b0;
          rpt_cnt <= '0;
        end else if (rpt_cnt == (rpt_first ? RPT_W'(REPEAT_DELAY - 1)
                                           : RPT_W'(REPEAT_RATE - 1))) begin
          if (rpt_dir) step_up   <= 1'b1;
          else         step_down <= 1'b1;
          rpt_first <= 1'b0;
          rpt_cnt   <= '0;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end

  assign mode   = mode_q;
  assign run_en = (mode_q == RUN);

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//   Scoreboard bench for time_set_ctrl. Stimulus pushes the expected strobe and
//   mode-change events (with the cycle they must appear on) into a queue; a
//   monitor pops and compares each event the DUT presents.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int TO  = 100;
  localparam int BD  = 8;
  localparam int LAT = DB + 3;

  localparam int K_UP   = 0;
  localparam int K_DN   = 1;
  localparam int K_MODE = 2;

  logic       clk50 = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b1;
  logic       btn_up = 1'b1;
  logic       btn_down = 1'b1;
  logic [1:0] mode;
  logic       step_up, step_down, run_en, blink;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int at;
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];

  time_set_ctrl #(
    .DEBOUNCE    (DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .TIMEOUT     (TO),
    .BLINK_DIV   (BD)
  ) dut (
    .clk50    (clk50),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .mode     (mode),
    .step_up  (step_up),
    .step_down(step_down),
    .run_en   (run_en),
    .blink    (blink)
  );

  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic expect_ev(input int at, input int kind, input int val);
    exp_q.push_back('{at, kind, val});
  endtask

  task automatic take_ev(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event at cycle %0d: got kind %0d value %0d, expected none",
               cyc, kind, val);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.at);
      check("event_value", val, e.val);
    end
  endtask

  // Monitor: every observed strobe or mode change must match the queue head.
  initial begin
    logic [1:0] prev;
    prev = 2'b00;
    forever begin
      @(negedge clk50);
      if (reset) begin
        prev = mode;
      end else begin
        if (step_up && step_down) check("strobe_overlap", 1, 0);
        if (mode != prev) begin
          take_ev(K_MODE, int'(mode));
          check("run_en_on_mode", int'(run_en), int'(mode == 2'b00));
          prev = mode;
        end
        if (step_up)   take_ev(K_UP, 0);
        if (step_down) take_ev(K_DN, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk50);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_mode = v;
      1:       btn_up   = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int b, input int hold, input int rel);
    set_btn(b, 1'b0);
    idle(hold);
    set_btn(b, 1'b1);
    idle(rel);
  endtask

  task automatic mode_press(input int new_mode);
    expect_ev(cyc + LAT, K_MODE, new_mode);
    press(0, 10, 10);
  endtask

  initial begin
    int t;
    int e;

    // Reset values, then idle in RUN.
    idle(3);
    check("rst_mode", int'(mode), 0);
    check("rst_step_up", int'(step_up), 0);
    check("rst_step_down", int'(step_down), 0);
    check("rst_run_en", int'(run_en), 1);
    check("rst_blink", int'(blink), 1);
    reset = 1'b0;
    idle(50);
    check("idle_mode", int'(mode), 0);
    check("idle_run_en", int'(run_en), 1);
    check("idle_blink", int'(blink), 1);

    // Full mode cycle.
    mode_press(1);
    check("set_run_en", int'(run_en), 0);
    mode_press(2);
    mode_press(3);
    mode_press(0);

    // SET_MIN: hold up. A 30-cycle hold releases the debounced level at t+36,
    // so exactly the initial strobe and two repeats (t+27, t+32) appear.
    mode_press(1);
    mode_press(2);
    t = cyc;
    expect_ev(t + LAT, K_UP, 0);
    expect_ev(t + LAT + RD, K_UP, 0);
    expect_ev(t + LAT + RD + RR, K_UP, 0);
    press(1, 30, 20);

    // SET_HOUR: 3-cycle glitch on down is filtered.
    mode_press(3);
    mode_press(0);
    mode_press(1);
    press(2, 3, 20);
    check("glitch_mode", int'(mode), 1);

    // RUN: up press is ignored.
    mode_press(2);
    mode_press(3);
    mode_press(0);
    press(1, 10, 20);
    check("run_mode", int'(mode), 0);

    // SET_SEC: up held, down added -> strobes stop; releasing down alone does
    // not resume; a fresh up press does.
    mode_press(1);
    mode_press(2);
    mode_press(3);
    t = cyc;
    expect_ev(t + LAT, K_UP, 0);
    btn_up = 1'b0;
    idle(12);
    btn_down = 1'b0;
    idle(28);
    btn_down = 1'b1;
    idle(40);
    btn_up = 1'b1;
    idle(10);
    t = cyc;
    expect_ev(t + LAT, K_UP, 0);
    press(1, 10, 20);
    mode_press(0);

    // Timeout from SET_HOUR with blink tracking.
    t = cyc;
    e = t + LAT;
    expect_ev(e, K_MODE, 1);
    expect_ev(e + TO, K_MODE, 0);
    btn_mode = 1'b0;
    idle(10);
    btn_mode = 1'b1;
    wait_cyc(e + BD - 1);
    check("blink_entry", int'(blink), 1);
    wait_cyc(e + BD);
    check("blink_first_toggle", int'(blink), 0);
    wait_cyc(e + 2 * BD - 1);
    check("blink_low_phase", int'(blink), 0);
    wait_cyc(e + 2 * BD);
    check("blink_second_toggle", int'(blink), 1);
    wait_cyc(e + 3 * BD);
    check("blink_third_toggle", int'(blink), 0);
    wait_cyc(e + 50);
    check("timeout_pending_mode", int'(mode), 1);
    check("timeout_pending_run_en", int'(run_en), 0);
    wait_cyc(e + TO - 1);
    check("timeout_last_set_mode", int'(mode), 1);
    check("timeout_last_blink", int'(blink), 1);
    wait_cyc(e + TO);
    check("timeout_mode", int'(mode), 0);
    check("timeout_run_en", int'(run_en), 1);
    check("timeout_blink", int'(blink), 1);
    wait_cyc(e + TO + 10);
    check("run_blink", int'(blink), 1);

    // Reset in the middle of an auto-repeat burst.
    idle(5);
    mode_press(1);
    t = cyc;
    expect_ev(t + LAT, K_UP, 0);
    expect_ev(t + LAT + RD, K_UP, 0);
    expect_ev(t + LAT + RD + RR, K_UP, 0);
    btn_up = 1'b0;
    wait_cyc(t + 35);
    @(posedge clk50);
    #2 reset = 1'b1;
    #1;
    check("midrst_mode", int'(mode), 0);
    check("midrst_step_up", int'(step_up), 0);
    check("midrst_step_down", int'(step_down), 0);
    check("midrst_run_en", int'(run_en), 1);
    check("midrst_blink", int'(blink), 1);
    idle(3);
    reset = 1'b0;
    idle(20);
    btn_up = 1'b1;
    idle(20);
    check("final_mode", int'(mode), 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
